uart_tx_arbiter: RTL

//  Shares the single UART TX-FIFO write port (wdata/wvalid/wready) between num_req byte producers.

---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX-FIFO write-port arbiter.
package uart_tx_arbiter_pkg;

    // FSM encodings; kept as plain constants so older tools can share them
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Default end-of-message byte (line feed)
    localparam logic [7:0] DEFAULT_EOP_CHAR = 8'h0A;

    // Burst and stall counters; parameter limits (<=255) keep them from wrapping
    typedef logic [7:0] cnt_t;

    // Compare "counter + 1" against a limit without losing the carry bit
    function automatic logic cnt_hits(input cnt_t cnt, input int limit);
        return ({1'b0, cnt} + 9'd1) == 9'(limit);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Searches last+1, last+2, ... (wrapping) and returns the first requester found, one-hot.
module uart_tx_arbiter_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               any_o,
    output logic [NUM_REQ-1:0] pick_o
);

    logic found;

    assign any_o = |req_i;

    // Two passes: indices above last first, then wrap around to 0..last
    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_i[j] && (j > int'(last_i))) begin
                pick_o[j] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_i[j] && (j <= int'(last_i))) begin
                pick_o[j] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the single UART TX-FIFO write port between byte producers.
// A grant is held for a whole message (until the EOP byte) so output lines never interleave;
// a burst limit and a stall timeout force release so no producer can hog the port.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no owner; pick next requester round-robin (1-cycle bubble)
//  ST_GRANT | owner's bytes pass straight through to the FIFO port
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    NUM_REQ      = 3,
    parameter logic [DATA_WIDTH-1:0] EOP_CHAR     = DEFAULT_EOP_CHAR,
    parameter int                    MAX_BURST    = 64,
    parameter int                    IDLE_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          wvalid,
    input  logic                          wready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int              IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    logic [0:0]         state_q,  state_d;
    logic [NUM_REQ-1:0] grant_q,  grant_d;
    logic [IDX_W-1:0]   owner_q,  owner_d;
    logic [IDX_W-1:0]   last_q,   last_d;
    cnt_t               burst_q,  burst_d;
    cnt_t               stall_q,  stall_d;

    logic                  pick_any;
    logic [NUM_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
    logic                  owner_valid;
    logic                  xfer;
    logic                  rel_eop, rel_burst, rel_idle, release_grant;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i  (req_valid),
        .last_i (last_q),
        .any_o  (pick_any),
        .pick_o (pick_oh)
    );

    // One-hot pick to owner index
    always_comb begin
        pick_idx = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick_oh[j]) pick_idx = IDX_W'(j);
        end
    end

    // Output mux: the owner talks to the FIFO directly; everything is 0 while idle
    always_comb begin
        wvalid      = 1'b0;
        wdata       = '0;
        req_ready   = '0;
        owner_valid = 1'b0;
        if (state_q == ST_GRANT) begin
            owner_valid        = req_valid[owner_q];
            wvalid             = owner_valid;
            wdata              = req_bytes[owner_q];
            req_ready[owner_q] = wready;
        end
    end

    assign xfer          = wvalid & wready;
    assign rel_eop       = xfer && (wdata == EOP_CHAR);
    assign rel_burst     = xfer && cnt_hits(burst_q, MAX_BURST);
    assign rel_idle      = (state_q == ST_GRANT) && !owner_valid && cnt_hits(stall_q, IDLE_TIMEOUT);
    assign release_grant = rel_eop | rel_burst | rel_idle;

    assign grant = grant_q;
    assign busy  = (state_q == ST_GRANT);

    // Next-state: arbitration in IDLE, counting and release decision in GRANT
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = burst_q;
        stall_d = stall_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    burst_d = '0;
                    stall_d = '0;
                end
            end
            ST_GRANT: begin
                if (release_grant) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                    burst_d = '0;
                    stall_d = '0;
                end else if (xfer) begin
                    burst_d = burst_q + 8'd1;
                    stall_d = '0;
                end else if (!owner_valid) begin
                    stall_d = stall_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and counter registers; reset abandons any message in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            burst_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            stall_q <= stall_d;
        end
    end

endmodule
